symbol_serializer: RTL and testbench
====================================

SYMBOL_SERIALIZER -- requirements
Module: symbol_serializer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 sym_i  input  10  encoded symbol {a,b,c,d,e,i,f,g,h,j}; sym_i[9] ('a') is transmitted first.
REQ-005 sym_rd_neg_i  input  1  running disparity after sym_i (1 = negative), from the upstream 5b6b/3b4b encode path.
REQ-006 sym_valid_i  input  1  sym_i and sym_rd_neg_i are valid.
REQ-007 sym_ready_o  output  1  block accepts a symbol this cycle; transfer occurs when sym_valid_i && sym_ready_o.
REQ-008 ser_o  output  1  serial bit, registered.
REQ-009 ser_valid_o  output  1  ser_o carries a symbol bit.
REQ-010 sym_start_o  output  1  one-cycle pulse coincident with the first bit ('a') of every transmitted symbol.
REQ-011 underflow_o  output  1  one-cycle pulse when a symbol boundary is reached with no symbol offered.

Function
REQ-012 States SHALL be IDLE (no transmission) and RUN (shifting); reset enters IDLE.
REQ-013 In RUN, a 4-bit bit counter SHALL count 0..9; each cycle it shifts one bit out and wraps 9->0.
REQ-014 sym_ready_o SHALL be 1 in IDLE and 1 in RUN when the counter is 9; otherwise it SHALL be 0. It SHALL NOT depend on sym_valid_i.
REQ-015 Latency: a symbol accepted in cycle N SHALL present bit 'a' on ser_o in cycle N+1, with sym_start_o=1 and ser_valid_o=1. Bits b..j SHALL follow in cycles N+2..N+10 with no gaps.
REQ-016 Back-to-back accepts at counter==9 SHALL produce a continuous bitstream with no idle cycles between symbols.
REQ-017 On accept, an internal rd_neg register SHALL load sym_rd_neg_i.
REQ-018 IDLE + transfer -> RUN with counter=0. IDLE with no transfer -> stay in IDLE with ser_o=0 and ser_valid_o=0.
REQ-019 RUN, counter==9, no sym_valid_i: behaviour is set by REQ-024/REQ-025, and underflow_o SHALL pulse for one cycle (the cycle of the missed boundary).
REQ-020 sym_i SHALL be sampled only on transfer; changes to sym_i while shifting SHALL NOT affect ser_o.

Reset
REQ-021 While reset_i=1, and asynchronously on its assertion, outputs SHALL be: ser_o=0, ser_valid_o=0, sym_start_o=0, underflow_o=0, sym_ready_o=0; state=IDLE; counter=0; shift register=0; rd_neg=1.
REQ-022 Reset asserted mid-symbol SHALL abort the symbol; no partial bits SHALL follow deassertion.
REQ-023 In the first cycle after deassertion, sym_ready_o SHALL be 1 (IDLE).

Configuration
REQ-024 With SER_IDLE_FILL_EN defined, an underflow in RUN SHALL load K28.5 chosen by rd_neg (rd_neg=1: 0011111010; rd_neg=0: 1100000101), invert rd_neg, and stay in RUN with sym_start_o pulsing normally.
REQ-025 Without SER_IDLE_FILL_EN, an underflow in RUN SHALL return to IDLE; ser_valid_o=0 and ser_o=0 from the next cycle.

Structure
REQ-026 Package pcie_phy_pkg SHALL hold SYM_W=10, K28_5_RDN, K28_5_RDP and the serializer state enum typedef.
REQ-027 No sub-module is required; the block is a single module with the shift register, counter and FSM.

Verification
REQ-028 Single symbol 10'b1001110100 with rd_neg 1, from IDLE -> ser_o = 1,0,0,1,1,1,0,1,0,0 in cycles N+1..N+10; sym_start_o only at N+1; then underflow_o pulses once.
REQ-029 Three back-to-back symbols held valid -> 30 contiguous ser_valid_o cycles, sym_start_o at offsets 1, 11 and 21, sym_ready_o high only at counter 9.
REQ-030 SER_IDLE_FILL_EN defined; symbol with sym_rd_neg_i=1, then valid deasserted -> ser_o carries 0011111010 then 1100000101, with underflow_o pulsing at each boundary.
REQ-031 SER_IDLE_FILL_EN undefined, same stimulus -> ser_valid_o drops after bit j and the FSM returns to IDLE; the next symbol restarts with 1-cycle latency.
REQ-032 reset_i pulsed at bit 4 of a symbol -> all outputs 0 immediately; after release sym_ready_o=1 and no residual bits appear.
REQ-033 sym_i toggled randomly while valid=0 and shifting -> the serial stream is unchanged.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// Shared constants and types for the PCIe PHY symbol path.
// Holds the symbol width, the two K28.5 comma encodings and the serializer state type.
package pcie_phy_pkg;

  localparam int SYM_W = 10;

  // K28.5 as transmitted a..j, selected by the running disparity before it
  localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

  // Bit counter value while the last bit ('j') of a symbol is on the line
  localparam logic [3:0] LAST_BIT = 4'd9;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_RUN  = 1'b1
  } ser_state_e;

endpackage

// File: rtl/symbol_serializer.sv
// 10-bit symbol to serial bitstream converter, 'a' (sym_i[9]) first.
// A symbol is accepted at a symbol boundary (IDLE, or last bit on the line) and
// its first bit appears on ser_o the following cycle, so back-to-back symbols
// form a gapless stream.
// Optional feature: define SER_IDLE_FILL_EN to transmit K28.5 (disparity-correct)
// instead of dropping to IDLE when no symbol is offered at a boundary.
module symbol_serializer
  import pcie_phy_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [SYM_W-1:0] sym_i,
  input  logic             sym_rd_neg_i,
  input  logic             sym_valid_i,
  output logic             sym_ready_o,
  output logic             ser_o,
  output logic             ser_valid_o,
  output logic             sym_start_o,
  output logic             underflow_o
);

  ser_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SYM_W-1:0] shift_q, shift_d;
  logic             ser_q, ser_d;
  logic             ser_valid_q, ser_valid_d;
  logic             start_q, start_d;
  logic             rd_neg_q, rd_neg_d;
  logic             at_boundary;
  logic             xfer;
`ifdef SER_IDLE_FILL_EN
  logic [SYM_W-1:0] fill_sym;
`endif

  // Handshake: ready only at a symbol boundary and never while in reset
  always_comb begin
    at_boundary = (state_q == SER_IDLE) || (cnt_q == LAST_BIT);
    sym_ready_o = at_boundary && !reset_i;
    xfer        = sym_ready_o && sym_valid_i;
    underflow_o = (state_q == SER_RUN) && (cnt_q == LAST_BIT) && !sym_valid_i;
  end

  // Next state: shift mid-symbol, load at a boundary, or fill/stop on underflow
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ser_d       = 1'b0;
    ser_valid_d = 1'b0;
    start_d     = 1'b0;
    rd_neg_d    = rd_neg_q;
`ifdef SER_IDLE_FILL_EN
    fill_sym    = rd_neg_q ? K28_5_RDN : K28_5_RDP;
`endif

    if ((state_q == SER_RUN) && (cnt_q != LAST_BIT)) begin
      // Mid-symbol: next bit comes from the top of the shift register. The
      // vacated LSB is backfilled with rd_neg; it is reloaded before it could
      // ever reach the top, so the fill value never reaches the line.
      cnt_d       = cnt_q + 4'd1;
      ser_d       = shift_q[SYM_W-1];
      ser_valid_d = 1'b1;
      shift_d     = {shift_q[SYM_W-2:0], rd_neg_q};
    end else if (xfer) begin
      // 'a' goes straight to the output register; b..j wait in the shifter
      state_d     = SER_RUN;
      cnt_d       = 4'd0;
      ser_d       = sym_i[SYM_W-1];
      ser_valid_d = 1'b1;
      start_d     = 1'b1;
      shift_d     = {sym_i[SYM_W-2:0], 1'b0};
      rd_neg_d    = sym_rd_neg_i;
    end else if (state_q == SER_RUN) begin
`ifdef SER_IDLE_FILL_EN
      // Boundary with nothing offered: keep the link busy with a comma
      cnt_d       = 4'd0;
      ser_d       = fill_sym[SYM_W-1];
      ser_valid_d = 1'b1;
      start_d     = 1'b1;
      shift_d     = {fill_sym[SYM_W-2:0], 1'b0};
      rd_neg_d    = ~rd_neg_q;
`else
      // Boundary with nothing offered: stop transmitting
      state_d     = SER_IDLE;
      cnt_d       = 4'd0;
      shift_d     = '0;
`endif
    end
  end

  // State registers; reset aborts any symbol in flight immediately
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= SER_IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= '0;
      ser_q       <= 1'b0;
      ser_valid_q <= 1'b0;
      start_q     <= 1'b0;
      rd_neg_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ser_q       <= ser_d;
      ser_valid_q <= ser_valid_d;
      start_q     <= start_d;
      rd_neg_q    <= rd_neg_d;
    end
  end

  assign ser_o       = ser_q;
  assign ser_valid_o = ser_valid_q;
  assign sym_start_o = start_q;

endmodule

// File: tb/tb_symbol_serializer.sv
// Self-checking bench for symbol_serializer. A queue-of-bits reference model
// predicts every output each cycle; stimulus mixes directed cases and random
// traffic with random sym_i churn. Honours SER_IDLE_FILL_EN like the design.
module tb_symbol_serializer;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [9:0] sym_i;
  logic       sym_rd_neg_i;
  logic       sym_valid_i;
  logic       sym_ready_o;
  logic       ser_o;
  logic       ser_valid_o;
  logic       sym_start_o;
  logic       underflow_o;

  symbol_serializer dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .sym_i        (sym_i),
    .sym_rd_neg_i (sym_rd_neg_i),
    .sym_valid_i  (sym_valid_i),
    .sym_ready_o  (sym_ready_o),
    .ser_o        (ser_o),
    .ser_valid_o  (ser_valid_o),
    .sym_start_o  (sym_start_o),
    .underflow_o  (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bits scheduled for future cycles, plus the one on the line now
  typedef struct packed {
    logic b;
    logic st;
    logic last;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  logic cur_valid;
  logic rd;
  logic accepted;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    cur       = '0;
    cur_valid = 1'b0;
    rd        = 1'b1;
  endtask

  task automatic push_sym(input logic [9:0] s);
    ent_t e;
    for (int i = 0; i < 10; i++) begin
      e.b    = s[9-i];
      e.st   = (i == 0);
      e.last = (i == 9);
      q.push_back(e);
    end
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance the model across the next posedge
  task automatic step(input logic rst_v, input logic v, input logic [9:0] s, input logic rdn);
    logic e_ready, e_under;
    @(negedge clk_i);
    reset_i      = rst_v;
    sym_valid_i  = v;
    sym_i        = s;
    sym_rd_neg_i = rdn;
    #1;
    accepted = 1'b0;
    if (rst_v) begin
      model_clear();
      e_ready = 1'b0;
      e_under = 1'b0;
    end else begin
      e_ready = !cur_valid || cur.last;
      e_under = cur_valid && cur.last && !v;
    end
    check_eq("ser_o",       ser_o,       cur_valid ? cur.b : 1'b0);
    check_eq("ser_valid_o", ser_valid_o, cur_valid);
    check_eq("sym_start_o", sym_start_o, cur_valid ? cur.st : 1'b0);
    check_eq("sym_ready_o", sym_ready_o, e_ready);
    check_eq("underflow_o", underflow_o, e_under);
    if (!rst_v) begin
      if (e_ready && v) begin
        push_sym(s);
        rd = rdn;
        accepted = 1'b1;
        $display("accept sym=%b rd_neg=%0b t=%0t", s, rdn, $time);
      end else if (e_under) begin
`ifdef SER_IDLE_FILL_EN
        push_sym(rd ? 10'b0011111010 : 10'b1100000101);
        rd = ~rd;
`endif
      end
      if (q.size() > 0) begin
        cur       = q.pop_front();
        cur_valid = 1'b1;
      end else begin
        cur_valid = 1'b0;
      end
    end
  endtask

  logic [9:0] got_bits;
  logic [9:0] syms3 [3];
  int         idx;
  int         thr;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; sym_valid_i = 1'b0; sym_i = '0; sym_rd_neg_i = 1'b0;
    model_clear();
    accepted = 1'b0;

    // Reset state: everything low, including ready
    repeat (3) step(1'b1, 1'b0, 10'h3ff, 1'b0);

    // Single symbol from IDLE, then starve the link
    step(1'b0, 1'b1, 10'b1001110100, 1'b1);
    check_eq("single_accept", accepted, 1'b1);
    got_bits = '0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 10'($urandom), 1'($urandom));
      got_bits = {got_bits[8:0], ser_o};
    end
    check_eq("single_bits", got_bits, 10'b1001110100);
    repeat (25) step(1'b0, 1'b0, 10'($urandom), 1'($urandom));

    // Three symbols held valid back-to-back
    syms3[0] = 10'b0101010101; syms3[1] = 10'b1110001100; syms3[2] = 10'b0011001101;
    idx = 0;
    for (int c = 0; c < 45; c++) begin
      step(1'b0, idx < 3, (idx < 3) ? syms3[idx] : 10'($urandom), 1'($urandom));
      if (accepted) idx++;
    end
    check_eq("b2b_accepts", idx, 3);

    // Reset asserted asynchronously at bit 4 of a symbol
    repeat (12) step(1'b0, 1'b1, 10'($urandom), 1'($urandom));
    for (int c = 0; c < 12 && !accepted; c++) step(1'b0, 1'b1, 10'($urandom), 1'($urandom));
    repeat (3) step(1'b0, 1'b0, 10'($urandom), 1'($urandom));
    @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    check_eq("arst_ser_o",       ser_o,       1'b0);
    check_eq("arst_ser_valid_o", ser_valid_o, 1'b0);
    check_eq("arst_sym_start_o", sym_start_o, 1'b0);
    check_eq("arst_underflow_o", underflow_o, 1'b0);
    check_eq("arst_sym_ready_o", sym_ready_o, 1'b0);
    model_clear();
    repeat (2) step(1'b1, 1'b1, 10'($urandom), 1'($urandom));
    repeat (14) step(1'b0, 1'b0, 10'($urandom), 1'($urandom));

    // Random traffic with varying offered load and constant sym_i churn
    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 0) thr = $urandom_range(2, 10);
      step(1'b0, $urandom_range(0, 9) < thr, 10'($urandom), 1'($urandom));
    end
    repeat (30) step(1'b0, 1'b0, 10'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
